// File: rtl/cyq_hc595_driver.sv
// Serialiser for a 74HC595 shift register: shifts one DATA_W-bit word out on
// ser/srclk, then pulses rclk to latch it, then pulses done for one cycle.
// Every output comes straight from a flop, so start/din never reach the pins
// combinationally.
module cyq_hc595_driver #(
   parameter int DATA_W    = 8,
   parameter int CLK_DIV   = 2,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rd,
   input  logic              start,
   input  logic [DATA_W-1:0] din,
   output logic              busy,
   output logic              done,
   output logic              ser,
   output logic              srclk,
   output logic              rclk
);

   localparam int BIT_W = $clog2(DATA_W) + 1;
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      LATCH,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ser_q, ser_d;
   logic              srclk_q, srclk_d;
   logic              rclk_q, rclk_d;
   logic              div_last;
   logic              bit_last;
   logic              out_bit;

   // Next-state logic; pin values are derived from the next state so that each
   // output flop is high for exactly the cycles its state is occupied.
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      div_last = (div_q == DIV_LAST);
      bit_last = (bit_q == BIT_LAST);

      case (state_q)
         IDLE: begin
            if (start) begin
               shreg_d = din;
               busy_d  = 1'b1;
               div_d   = '0;
               bit_d   = '0;
               state_d = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (div_last) begin
               div_d   = '0;
               state_d = SHIFT_HI;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         SHIFT_HI: begin
            if (div_last) begin
               div_d   = '0;
               shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
               if (bit_last) begin
                  state_d = LATCH;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  state_d = SHIFT_LO;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         LATCH: begin
            if (div_last) begin
               div_d   = '0;
               state_d = DONE;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            bit_d   = '0;
            div_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      out_bit = (MSB_FIRST != 0) ? shreg_d[DATA_W-1] : shreg_d[0];
      srclk_d = (state_d == SHIFT_HI);
      rclk_d  = (state_d == LATCH);
      ser_d   = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? out_bit : 1'b0;
   end

   // State and output registers; reset drops every pin low at once.
   always_ff @(posedge clk or negedge rd) begin
      if (!rd) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ser_q   <= 1'b0;
         srclk_q <= 1'b0;
         rclk_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ser_q   <= ser_d;
         srclk_q <= srclk_d;
         rclk_q  <= rclk_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign ser   = ser_q;
   assign srclk = srclk_q;
   assign rclk  = rclk_q;

endmodule
